pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Front-end sequencing controller for the 20-bit pipelined processor: each cycle decides whether the PC advances, whether the IF/ID pipeline register captures, holds or loads a NOP, and whether a bubble is injected into ID/EX. It resolves three hazards in fixed priority:

- taken-branch redirect
- load-use data hazard
- instruction-memory wait

It also keeps saturating stall/flush statistics and a sticky fetch-timeout error. Sits beside the PC register, IF/ID register and ID/EX register; all its control outputs feed their enables/clears directly.

## Interface
- REG_ADDR_W, 3, width of register-file address fields
- WAIT_LIMIT, 15, consecutive imem-wait cycles that set imem_err (1..255)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  REG_ADDR_W  rs field of instruction in IF/ID
- id_rt  in  REG_ADDR_W  rt field of instruction in IF/ID
- id_uses_rt  in  1  instruction in IF/ID reads rt
- ex_mem_read  in  1  instruction in ID/EX is a load
- ex_rd  in  REG_ADDR_W  destination register of instruction in ID/EX
- branch_taken  in  1  branch in EX resolved taken this cycle
- imem_ready  in  1  instruction memory presents a valid instruction this cycle
- pc_write  out  1  PC register load enable
- pc_redirect  out  1  PC mux selects branch target
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads NOP (0x00000) instead of fetched data; only meaningful with ifid_write=1
- idex_bubble  out  1  ID/EX loads all-zero control
- fetch_wait  out  1  FSM in WAIT state (registered)
- imem_err  out  1  sticky fetch-timeout flag (registered)
- stall_cnt  out  16  saturating count of stall cycles (registered)
- flush_cnt  out  16  saturating count of branch flushes (registered)

## Operation
- Control outputs (pc_write, pc_redirect, ifid_write, ifid_flush, idex_bubble) are combinational from inputs and rst. The first matching case wins:
  - **R, rst=1:** pc_write=0, pc_redirect=0, ifid_write=1, ifid_flush=1, idex_bubble=1. This clears the pipe during reset.
  - **B, branch_taken=1:** pc_write=1, pc_redirect=1, ifid_write=1, ifid_flush=1, idex_bubble=1. flush_cnt+1.
  - **L, load-use:** defined as ex_mem_read & (ex_rd≠0) & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
    - Outputs: pc_write=0, pc_redirect=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
    - stall_cnt+1.
    - Register 0 never causes a hazard.
  - **W, imem_ready=0:** pc_write=0, pc_redirect=0, ifid_write=1, ifid_flush=1, idex_bubble=0. The back end drains while a NOP enters ID. stall_cnt+1.
  - **N, otherwise:** pc_write=1, ifid_write=1, all others 0.
- FSM states and transitions, evaluated at the clock edge:
  - States: RUN, WAIT.
  - RUN→WAIT on case W.
  - WAIT→RUN on case N or B.
  - Case L holds the current state.
- wait_cnt (8-bit, internal):
  - Clears on entry to RUN.
  - Increments (saturating at WAIT_LIMIT) on each case-W cycle.
  - Holds on case L.
- imem_err is set when wait_cnt reaches WAIT_LIMIT; it clears only on rst.
- stall_cnt and flush_cnt saturate at 0xFFFF and never wrap.

## Timing
- Reset values (registered outputs): fetch_wait=0, imem_err=0, stall_cnt=0, flush_cnt=0. FSM=RUN, wait_cnt=0.
- Control outputs have zero latency: they are valid in the same cycle as their inputs.
- Registered outputs update on the edge ending the triggering cycle.
- A load-use stall lasts exactly one cycle, because the next cycle ID/EX holds the bubble (ex_mem_read=0).
- Case B during WAIT abandons the pending fetch: the PC loads the target and the FSM returns to RUN.
- Case L with imem_ready=0: L wins. IF/ID holds, stall counted once, wait_cnt unchanged.
- Case B with load-use: B wins. The hazard is squashed with the wrong-path instruction.
- rst asserted mid-WAIT: next cycle FSM=RUN, counters=0, imem_err=0.
- imem_err asserts on the edge where wait_cnt becomes WAIT_LIMIT. With the default limit, that is after the 15th consecutive W cycle counted from the RUN→WAIT edge.

## Test plan
- **Reset:** hold rst for 2 cycles with random inputs → pc_write=0, ifid_flush=1, idex_bubble=1. After release: stall_cnt=0, flush_cnt=0, fetch_wait=0.
- **Load-use:** ex_mem_read=1, ex_rd=3, id_rs=3 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1, stall_cnt=1. Repeat with ex_rd=0 → no stall.
- **Branch with hazard:** branch_taken=1 while load-use and imem_ready=0 are both true → pc_redirect=1, ifid_flush=1, idex_bubble=1. flush_cnt=1, stall_cnt unchanged, fetch_wait=0 next cycle.
- **Memory wait:** imem_ready=0 for 4 cycles → fetch_wait=1 from cycle 2, ifid_flush=1 each cycle, stall_cnt=4. On imem_ready=1: pc_write=1 and fetch_wait=0 next cycle.
- **Timeout:** imem_ready=0 for 20 cycles → imem_err=1 after the 15th cycle. imem_ready=1 → imem_err stays 1 until rst.
- **Saturation:** force 65 540 stall cycles → stall_cnt=0xFFFF, no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Front-end sequencing controller for the 20-bit pipelined processor. Each
// cycle it decides whether the PC advances, whether IF/ID captures, holds or
// loads a NOP, and whether a bubble is injected into ID/EX. Hazards are
// resolved in fixed priority: reset, taken branch, load-use, imem wait.
// It also keeps saturating stall/flush statistics and a sticky fetch-timeout
// flag.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   id_rs, id_rt    source register fields of the instruction in IF/ID
//   id_uses_rt      instruction in IF/ID reads rt
//   ex_mem_read     instruction in ID/EX is a load
//   ex_rd           destination register of the instruction in ID/EX
//   branch_taken    branch in EX resolved taken this cycle
//   imem_ready      instruction memory presents a valid instruction
//   pc_write        PC load enable                        (combinational)
//   pc_redirect     PC mux selects branch target          (combinational)
//   ifid_write      IF/ID load enable                     (combinational)
//   ifid_flush      IF/ID loads NOP instead of fetch data (combinational)
//   idex_bubble     ID/EX loads all-zero control          (combinational)
//   fetch_wait      controller is in the WAIT state       (registered)
//   imem_err        sticky fetch-timeout flag             (registered)
//   stall_cnt       saturating count of stall cycles      (registered)
//   flush_cnt       saturating count of branch flushes    (registered)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  imem_ready,
    output logic                  pc_write,
    output logic                  pc_redirect,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  fetch_wait,
    output logic                  imem_err,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
);

    typedef enum logic [2:0] {
        HZ_RESET,
        HZ_BRANCH,
        HZ_LOAD_USE,
        HZ_IMEM_WAIT,
        HZ_NONE
    } hazard_e;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } state_e;

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_e     state, state_nxt;
    hazard_e    hazard;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       imem_err_nxt;
    logic       load_use;

    // Register 0 is hard-wired zero, so a load targeting it never hazards.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // Priority classification: the first matching case wins.
    always_comb begin
        if (rst)               hazard = HZ_RESET;
        else if (branch_taken) hazard = HZ_BRANCH;
        else if (load_use)     hazard = HZ_LOAD_USE;
        else if (!imem_ready)  hazard = HZ_IMEM_WAIT;
        else                   hazard = HZ_NONE;
    end

    // Control outputs and next-state logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        pc_write     = 1'b0;
        pc_redirect  = 1'b0;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        imem_err_nxt = imem_err;

        unique case (hazard)
            HZ_RESET: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            HZ_BRANCH: begin
                // Squashes any pending fetch and any wrong-path hazard.
                pc_write     = 1'b1;
                pc_redirect  = 1'b1;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
            HZ_LOAD_USE: begin
                // Hold IF/ID and PC; FSM and wait_cnt freeze for this cycle.
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            HZ_IMEM_WAIT: begin
                // Back end drains while a NOP enters ID.
                ifid_flush = 1'b1;
                state_nxt  = ST_WAIT;
                if (wait_cnt < WAIT_LIMIT_C) wait_cnt_nxt = wait_cnt + 8'd1;
                if (wait_cnt_nxt == WAIT_LIMIT_C) imem_err_nxt = 1'b1;
            end
            default: begin
                pc_write     = 1'b1;
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            imem_err  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            imem_err <= imem_err_nxt;
            if ((hazard == HZ_LOAD_USE || hazard == HZ_IMEM_WAIT) &&
                stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (hazard == HZ_BRANCH && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign fetch_wait = (state == ST_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed self-checking bench for pipeline_hazard_ctrl. Inputs are driven
// 1 ns after the rising edge; combinational outputs are sampled 1 ns after
// the drive, registered outputs 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, ex_rd;
    logic          id_uses_rt, ex_mem_read, branch_taken, imem_ready;
    logic          pc_write, pc_redirect, ifid_write, ifid_flush, idex_bubble;
    logic          fetch_wait, imem_err;
    logic [15:0]   stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .WAIT_LIMIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .pc_write     (pc_write),
        .pc_redirect  (pc_redirect),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .fetch_wait   (fetch_wait),
        .imem_err     (imem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare the five combinational controls as one packed vector:
    // {pc_write, pc_redirect, ifid_write, ifid_flush, idex_bubble}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        #1;
        check(tag, {27'd0, pc_write, pc_redirect, ifid_write, ifid_flush,
                    idex_bubble}, {27'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst          = 1'b0;
        branch_taken = 1'b0;
        ex_mem_read  = 1'b0;
        ex_rd        = '0;
        id_rs        = 3'd1;
        id_rt        = 3'd2;
        id_uses_rt   = 1'b0;
        imem_ready   = 1'b1;
    endtask

    task automatic load_use_rs3;
        ex_mem_read = 1'b1;
        ex_rd       = 3'd3;
        id_rs       = 3'd3;
    endtask

    localparam logic [4:0] CTL_R = 5'b00111;
    localparam logic [4:0] CTL_B = 5'b11111;
    localparam logic [4:0] CTL_L = 5'b00001;
    localparam logic [4:0] CTL_W = 5'b00110;
    localparam logic [4:0] CTL_N = 5'b10100;

    initial begin
        // ---- Reset with random inputs ----
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {id_rs, id_rt, ex_rd} = 9'($urandom);
            {id_uses_rt, ex_mem_read, branch_taken, imem_ready} = 4'($urandom);
            check_ctl("reset_ctl", CTL_R);
            tick;
        end
        idle;
        check_ctl("idle_ctl", CTL_N);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        check("rst_fetch_wait", fetch_wait, 0);
        check("rst_imem_err", imem_err, 0);
        tick;

        // ---- Load-use on rs ----
        load_use_rs3;
        check_ctl("lu_rs_ctl", CTL_L);
        tick;
        ex_mem_read = 1'b0;
        check_ctl("lu_after_ctl", CTL_N);
        check("lu_stall", stall_cnt, 1);
        check("lu_fetch_wait", fetch_wait, 0);
        tick;

        // ---- Register 0 never hazards ----
        ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs = 3'd0;
        check_ctl("lu_r0_ctl", CTL_N);
        tick;
        check("lu_r0_stall", stall_cnt, 1);

        // ---- rt match only counts when rt is read ----
        ex_rd = 3'd5; id_rs = 3'd1; id_rt = 3'd5; id_uses_rt = 1'b0;
        check_ctl("lu_rt_unused_ctl", CTL_N);
        id_uses_rt = 1'b1;
        check_ctl("lu_rt_ctl", CTL_L);
        tick;
        idle;
        check("lu_rt_stall", stall_cnt, 2);

        // ---- Branch with load-use and imem wait ----
        load_use_rs3;
        imem_ready   = 1'b0;
        branch_taken = 1'b1;
        check_ctl("br_hz_ctl", CTL_B);
        tick;
        idle;
        check("br_flush", flush_cnt, 1);
        check("br_stall", stall_cnt, 2);
        check("br_fetch_wait", fetch_wait, 0);

        // ---- Memory wait, 4 cycles ----
        imem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check_ctl("mw_ctl", CTL_W);
            check("mw_fetch_wait_pre", fetch_wait, (i == 1) ? 0 : 1);
            tick;
        end
        check("mw_stall", stall_cnt, 6);
        check("mw_fetch_wait", fetch_wait, 1);

        // ---- Load-use beats imem wait; FSM holds WAIT ----
        load_use_rs3;
        check_ctl("lu_in_wait_ctl", CTL_L);
        tick;
        ex_mem_read = 1'b0;
        check("lu_in_wait_state", fetch_wait, 1);
        check("lu_in_wait_stall", stall_cnt, 7);

        imem_ready = 1'b1;
        check_ctl("mw_done_ctl", CTL_N);
        tick;
        check("mw_done_fetch_wait", fetch_wait, 0);
        check("mw_done_stall", stall_cnt, 7);

        // ---- Branch during WAIT abandons the fetch ----
        imem_ready = 1'b0;
        tick;
        check("bw_fetch_wait", fetch_wait, 1);
        branch_taken = 1'b1;
        check_ctl("bw_ctl", CTL_B);
        tick;
        idle;
        check("bw_fetch_wait_after", fetch_wait, 0);
        check("bw_flush", flush_cnt, 2);
        check("bw_stall", stall_cnt, 8);

        // ---- Timeout: 20 wait cycles ----
        imem_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 14) check("to_err_14", imem_err, 0);
            if (i == 15) check("to_err_15", imem_err, 1);
        end
        check("to_stall", stall_cnt, 28);
        imem_ready = 1'b1;
        tick;
        check("to_sticky_1", imem_err, 1);
        check("to_fetch_wait", fetch_wait, 0);
        tick;
        check("to_sticky_2", imem_err, 1);

        // ---- Reset asserted mid-WAIT ----
        imem_ready = 1'b0;
        tick;
        tick;
        check("rw_in_wait", fetch_wait, 1);
        rst = 1'b1;
        check_ctl("rw_ctl", CTL_R);
        tick;
        idle;
        check("rw_fetch_wait", fetch_wait, 0);
        check("rw_imem_err", imem_err, 0);
        check("rw_stall", stall_cnt, 0);
        check("rw_flush", flush_cnt, 0);

        // ---- Stall counter saturation ----
        load_use_rs3;
        repeat (65534) tick;
        check("sat_fffe", stall_cnt, 16'hFFFE);
        repeat (6) tick;
        check("sat_ffff", stall_cnt, 16'hFFFF);
        check("sat_flush", flush_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
